// File: rtl/sdram_req_queue.sv
// Request FIFO in front of a single-outstanding SDRAM controller. Issue is
// held off until the controller power-up interval has elapsed.
module sdram_req_queue #(
  parameter int INIT_CYCLES = 5100,
  parameter int DEPTH       = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [24:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        resp_valid,
  output logic [15:0] resp_rdata,
  output logic        init_done,
  output logic        busy,
  output logic        mem_write_en,
  output logic [24:0] mem_addr,
  output logic [15:0] mem_data_in,
  output logic        mem_refresh_data,
  input  logic [15:0] mem_data_out,
  input  logic        mem_data_ready
);

  localparam int AW = $clog2(DEPTH);
  localparam int NW = AW + 1;
  localparam int CW = $clog2(INIT_CYCLES + 1);
  localparam int EW = 42;
  localparam logic [NW-1:0] FULL      = NW'(DEPTH);
  localparam logic [CW-1:0] INIT_LAST = CW'(INIT_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_INIT   = 3'd0,
    ST_IDLE   = 3'd1,
    ST_ISSUE  = 3'd2,
    ST_SETTLE = 3'd3,
    ST_WAIT   = 3'd4
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [CW-1:0] init_cnt;
  logic [EW-1:0] fifo_mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [NW-1:0] count;
  logic          push;
  logic          pop;
  logic          done;

  assign req_ready = (count != FULL);
  assign push      = req_valid && req_ready;
  assign busy      = (state == ST_ISSUE) || (state == ST_SETTLE) ||
                     (state == ST_WAIT) || (count != '0);

  // Sequencer next state; the controller's ready flag is only looked at in
  // WAIT so a level left over from the previous transaction is ignored.
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    done       = 1'b0;
    case (state)
      ST_INIT: begin
        if (init_cnt == INIT_LAST) state_next = ST_IDLE;
        else                       state_next = ST_INIT;
      end
      ST_IDLE: begin
        if (count != '0) begin
          state_next = ST_ISSUE;
          pop        = 1'b1;
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_ISSUE:  state_next = ST_SETTLE;
      ST_SETTLE: state_next = ST_WAIT;
      ST_WAIT: begin
        if (mem_data_ready) begin
          state_next = ST_IDLE;
          done       = 1'b1;
        end else begin
          state_next = ST_WAIT;
        end
      end
      default: state_next = ST_INIT;
    endcase
  end

  // State register, power-up counter and state-decoded outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state            <= ST_INIT;
      init_cnt         <= '0;
      init_done        <= 1'b0;
      mem_refresh_data <= 1'b0;
    end else begin
      state            <= state_next;
      init_done        <= (state_next != ST_INIT);
      mem_refresh_data <= (state_next == ST_ISSUE);
      if (state == ST_INIT) init_cnt <= init_cnt + CW'(1);
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + NW'(1);
        2'b01:   count <= count - NW'(1);
        default: count <= count;
      endcase
    end
  end

  // FIFO storage; contents are don't-care while count says empty.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {req_write, req_addr, req_wdata};
  end

  // Controller command registers, loaded on pop and held until the next one.
  always_ff @(posedge clk) begin
    if (!rst) begin
      mem_write_en <= 1'b0;
      mem_addr     <= 25'd0;
      mem_data_in  <= 16'd0;
    end else if (pop) begin
      {mem_write_en, mem_addr, mem_data_in} <= fifo_mem[rd_ptr];
    end
  end

  // Completion pulse and captured read data.
  always_ff @(posedge clk) begin
    if (!rst) begin
      resp_valid <= 1'b0;
      resp_rdata <= 16'd0;
    end else begin
      resp_valid <= done;
      if (done) resp_rdata <= mem_data_out;
    end
  end

endmodule

// File: tb/tb_sdram_req_queue.sv
// Randomised bench for sdram_req_queue: a behavioural SDRAM controller model
// plus an in-order reference memory that predicts every issue and response.
module tb_sdram_req_queue;

  localparam int INIT_CYCLES = 20;
  localparam int DEPTH       = 4;

  typedef struct packed {
    logic        w;
    logic [24:0] a;
    logic [15:0] d;
  } req_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [24:0] req_addr = 25'd0;
  logic [15:0] req_wdata = 16'd0;
  logic        req_ready;
  logic        resp_valid;
  logic [15:0] resp_rdata;
  logic        init_done;
  logic        busy;
  logic        mem_write_en;
  logic [24:0] mem_addr;
  logic [15:0] mem_data_in;
  logic        mem_refresh_data;
  logic [15:0] mem_data_out = 16'd0;
  logic        mem_data_ready = 1'b0;

  sdram_req_queue #(.INIT_CYCLES(INIT_CYCLES), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .init_done(init_done), .busy(busy),
    .mem_write_en(mem_write_en), .mem_addr(mem_addr), .mem_data_in(mem_data_in),
    .mem_refresh_data(mem_refresh_data),
    .mem_data_out(mem_data_out), .mem_data_ready(mem_data_ready)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int last_ref = -100;
  int spacing_bad = 0;
  int ctl_stale = -1;
  int ctl_lat = -1;

  req_t        exp_issue[$];
  req_t        obs_issue[$];
  logic [15:0] exp_resp[$];
  logic [15:0] obs_resp[$];
  logic [15:0] ref_mem[int];
  logic [15:0] sdram[int];

  function automatic logic [15:0] rd_default(input logic [24:0] a);
    return a[15:0] ^ 16'hA5C3;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: records every command pulse and every response pulse.
  initial begin
    forever begin
      @(negedge clk);
      if (mem_refresh_data === 1'b1) begin
        if (cyc - last_ref < 4) spacing_bad++;
        last_ref = cyc;
        obs_issue.push_back(req_t'{mem_write_en, mem_addr, mem_data_in});
      end
      if (resp_valid === 1'b1) obs_resp.push_back(resp_rdata);
    end
  end

  // Controller model: data_ready stays high after a completion and is only
  // cleared 0..2 cycles after the next command, then re-asserted later.
  logic        c_w;
  logic [24:0] c_a;
  logic [15:0] c_d;
  int          c_stale;
  int          c_lat;
  initial begin
    forever begin
      @(negedge clk);
      if (mem_refresh_data === 1'b1) begin
        c_w = mem_write_en;
        c_a = mem_addr;
        c_d = mem_data_in;
        c_stale = (ctl_stale >= 0) ? ctl_stale : int'($urandom_range(0, 2));
        c_lat   = (ctl_lat >= 0) ? ctl_lat : int'($urandom_range(1, 4));
        repeat (c_stale) @(negedge clk);
        mem_data_ready = 1'b0;
        repeat (c_lat) @(negedge clk);
        if (c_w) sdram[int'(c_a)] = c_d;
        mem_data_out = sdram.exists(int'(c_a)) ? sdram[int'(c_a)] : rd_default(c_a);
        mem_data_ready = 1'b1;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected bench completion");
    $fatal(1, "watchdog expired");
  end

  task automatic clear_all();
    exp_issue.delete();
    obs_issue.delete();
    exp_resp.delete();
    obs_resp.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    clear_all();
    last_ref = -100;
    rst = 1'b1;
  endtask

  // Present one request starting at a negedge; returns at the negedge after
  // the accepting edge and records the predicted issue and response.
  task automatic push_req(input logic w, input logic [24:0] a, input logic [15:0] d,
                          output int waited, output int issued);
    req_t r;
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    waited = 0;
    #1;
    while (req_ready !== 1'b1 && waited < 5000) begin
      @(negedge clk);
      #1;
      waited++;
    end
    issued = obs_issue.size();
    r = '{w, a, d};
    exp_issue.push_back(r);
    if (w) begin
      ref_mem[int'(a)] = d;
      exp_resp.push_back(d);
    end else if (ref_mem.exists(int'(a))) begin
      exp_resp.push_back(ref_mem[int'(a)]);
    end else begin
      exp_resp.push_back(rd_default(a));
    end
    @(negedge clk);
  endtask

  task automatic drain(output bit ok);
    int t = 0;
    while (obs_resp.size() < exp_resp.size() && t < 3000) begin
      @(negedge clk);
      t++;
    end
    repeat (8) @(negedge clk);
    #1;
    ok = (t < 3000);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({req_ready, resp_valid, init_done, busy, mem_refresh_data, mem_write_en} !== 6'b100000) begin
      n_bad++;
      $display("FAIL reset_flags: got %b expected 100000",
               {req_ready, resp_valid, init_done, busy, mem_refresh_data, mem_write_en});
    end
    n_cmp++;
    if (resp_rdata !== 16'd0) begin
      n_bad++;
      $display("FAIL reset_rdata: got %h expected 0000", resp_rdata);
    end
    n_cmp++;
    if (mem_addr !== 25'd0) begin
      n_bad++;
      $display("FAIL reset_addr: got %h expected 0", mem_addr);
    end
    n_cmp++;
    if (mem_data_in !== 16'd0) begin
      n_bad++;
      $display("FAIL reset_data_in: got %h expected 0000", mem_data_in);
    end
    clear_all();
    rst = 1'b1;
  endtask

  task automatic test_init();
    int k = 0;
    bit seen_ref = 1'b0;
    while (init_done !== 1'b1 && k < INIT_CYCLES + 20) begin
      @(posedge clk);
      #1;
      k++;
      if (mem_refresh_data !== 1'b0) seen_ref = 1'b1;
    end
    repeat (6) begin
      @(posedge clk);
      #1;
      if (mem_refresh_data !== 1'b0) seen_ref = 1'b1;
    end
    n_cmp++;
    if (k !== INIT_CYCLES) begin
      n_bad++;
      $display("FAIL init_latency: got %0d cycles expected %0d", k, INIT_CYCLES);
    end
    n_cmp++;
    if (seen_ref !== 1'b0) begin
      n_bad++;
      $display("FAIL init_no_refresh: got pulse=%0b expected 0", seen_ref);
    end
  endtask

  task automatic test_single_write();
    int  w;
    int  s;
    bit  ok;
    @(negedge clk);
    push_req(1'b1, 25'h0000123, 16'hBEEF, w, s);
    req_valid = 1'b0;
    drain(ok);
    n_cmp++;
    if (ok !== 1'b1) begin
      n_bad++;
      $display("FAIL single_timeout: got timeout expected response");
    end
    n_cmp++;
    if (obs_issue.size() !== 1) begin
      n_bad++;
      $display("FAIL single_issue_count: got %0d expected 1", obs_issue.size());
    end else begin
      n_cmp++;
      if (obs_issue[0] !== req_t'{1'b1, 25'h0000123, 16'hBEEF}) begin
        n_bad++;
        $display("FAIL single_issue: got %h expected %h", obs_issue[0], req_t'{1'b1, 25'h0000123, 16'hBEEF});
      end
    end
    n_cmp++;
    if (obs_resp.size() !== 1) begin
      n_bad++;
      $display("FAIL single_resp_count: got %0d expected 1", obs_resp.size());
    end else begin
      n_cmp++;
      if (obs_resp[0] !== 16'hBEEF) begin
        n_bad++;
        $display("FAIL single_resp: got %h expected BEEF", obs_resp[0]);
      end
    end
    clear_all();
  endtask

  task automatic test_stale_ready();
    int w;
    int s;
    bit ok;
    ctl_stale = 2;
    ctl_lat = 1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      push_req(1'b1, 25'h0002000 + 25'(i), 16'h1111 * 16'(i + 1), w, s);
    end
    req_valid = 1'b0;
    drain(ok);
    ctl_stale = -1;
    ctl_lat = -1;
    n_cmp++;
    if (obs_resp.size() !== exp_resp.size()) begin
      n_bad++;
      $display("FAIL stale_resp_count: got %0d expected %0d", obs_resp.size(), exp_resp.size());
    end
    for (int i = 0; i < exp_resp.size() && i < obs_resp.size(); i++) begin
      n_cmp++;
      if (obs_resp[i] !== exp_resp[i]) begin
        n_bad++;
        $display("FAIL stale_resp[%0d]: got %h expected %h", i, obs_resp[i], exp_resp[i]);
      end
    end
    clear_all();
  endtask

  task automatic test_push_pop_same();
    int w;
    int s;
    bit ok;
    @(negedge clk);
    push_req(1'b0, 25'h0000400, 16'h0, w, s);
    push_req(1'b1, 25'h0000401, 16'h5AA5, w, s);
    req_valid = 1'b0;
    n_cmp++;
    if (dut.count !== 3'd1) begin
      n_bad++;
      $display("FAIL pushpop_count: got %0d expected 1", dut.count);
    end
    drain(ok);
    n_cmp++;
    if (obs_issue.size() !== 2 || obs_resp.size() !== 2) begin
      n_bad++;
      $display("FAIL pushpop_sizes: got %0d/%0d expected 2/2", obs_issue.size(), obs_resp.size());
    end
    for (int i = 0; i < 2 && i < obs_issue.size() && i < obs_resp.size(); i++) begin
      n_cmp++;
      if (obs_issue[i] !== exp_issue[i] || obs_resp[i] !== exp_resp[i]) begin
        n_bad++;
        $display("FAIL pushpop[%0d]: got %h/%h expected %h/%h", i, obs_issue[i], obs_resp[i],
                 exp_issue[i], exp_resp[i]);
      end
    end
    clear_all();
  endtask

  task automatic test_random();
    int w;
    int s;
    bit ok;
    logic [24:0] a;
    @(negedge clk);
    for (int i = 0; i < 40; i++) begin
      a = 25'h01F0000 + 25'($urandom_range(0, 7));
      push_req(1'($urandom_range(0, 1)), a, 16'($urandom), w, s);
      if ($urandom_range(0, 1) == 1) begin
        req_valid = 1'b0;
        repeat ($urandom_range(1, 6)) @(negedge clk);
      end
    end
    req_valid = 1'b0;
    drain(ok);
    n_cmp++;
    if (ok !== 1'b1 || obs_issue.size() !== exp_issue.size() || obs_resp.size() !== exp_resp.size()) begin
      n_bad++;
      $display("FAIL rand_counts: got %0d issues %0d resps expected %0d %0d", obs_issue.size(),
               obs_resp.size(), exp_issue.size(), exp_resp.size());
    end
    for (int i = 0; i < exp_issue.size() && i < obs_issue.size(); i++) begin
      n_cmp++;
      if (obs_issue[i] !== exp_issue[i]) begin
        n_bad++;
        $display("FAIL rand_issue[%0d]: got %h expected %h", i, obs_issue[i], exp_issue[i]);
      end
    end
    for (int i = 0; i < exp_resp.size() && i < obs_resp.size(); i++) begin
      n_cmp++;
      if (obs_resp[i] !== exp_resp[i]) begin
        n_bad++;
        $display("FAIL rand_resp[%0d]: got %h expected %h", i, obs_resp[i], exp_resp[i]);
      end
    end
    n_cmp++;
    if (spacing_bad !== 0) begin
      n_bad++;
      $display("FAIL refresh_spacing: got %0d short gaps expected 0", spacing_bad);
    end
    clear_all();
  endtask

  task automatic test_init_backlog();
    int w;
    int s;
    bit ok;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      push_req(1'($urandom_range(0, 1)), 25'h0000800 + 25'($urandom_range(0, 3)), 16'($urandom), w, s);
      if (i < 4) begin
        n_cmp++;
        if (w !== 0) begin
          n_bad++;
          $display("FAIL backlog_accept[%0d]: got wait %0d expected 0", i, w);
        end
      end else begin
        n_cmp++;
        if (w === 0 || s !== 1) begin
          n_bad++;
          $display("FAIL backlog_fifth: got wait %0d issued %0d expected wait>0 issued 1", w, s);
        end
      end
    end
    req_valid = 1'b0;
    drain(ok);
    n_cmp++;
    if (ok !== 1'b1 || obs_issue.size() !== 5 || obs_resp.size() !== 5) begin
      n_bad++;
      $display("FAIL backlog_counts: got %0d issues %0d resps expected 5 5", obs_issue.size(), obs_resp.size());
    end
    for (int i = 0; i < 5 && i < obs_issue.size() && i < obs_resp.size(); i++) begin
      n_cmp++;
      if (obs_issue[i] !== exp_issue[i] || obs_resp[i] !== exp_resp[i]) begin
        n_bad++;
        $display("FAIL backlog[%0d]: got %h/%h expected %h/%h", i, obs_issue[i], obs_resp[i],
                 exp_issue[i], exp_resp[i]);
      end
    end
    clear_all();
  endtask

  task automatic test_reset_in_wait();
    int w;
    int s;
    int t = 0;
    ctl_lat = 30;
    @(negedge clk);
    for (int i = 0; i < 3; i++) push_req(1'b0, 25'h0000300 + 25'(i), 16'h0, w, s);
    req_valid = 1'b0;
    while (obs_issue.size() == 0 && t < 200) begin
      @(negedge clk);
      #1;
      t++;
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({req_ready, resp_valid, init_done, busy, mem_refresh_data, mem_write_en} !== 6'b100000) begin
      n_bad++;
      $display("FAIL wait_reset_flags: got %b expected 100000",
               {req_ready, resp_valid, init_done, busy, mem_refresh_data, mem_write_en});
    end
    n_cmp++;
    if (resp_rdata !== 16'd0 || mem_addr !== 25'd0 || mem_data_in !== 16'd0 || dut.count !== 3'd0) begin
      n_bad++;
      $display("FAIL wait_reset_regs: got rdata %h addr %h din %h count %0d expected all 0",
               resp_rdata, mem_addr, mem_data_in, dut.count);
    end
    rst = 1'b1;
    clear_all();
    ctl_lat = -1;
    repeat (60) @(negedge clk);
    #1;
    n_cmp++;
    if (obs_resp.size() !== 0 || obs_issue.size() !== 0) begin
      n_bad++;
      $display("FAIL wait_reset_abandon: got %0d resps %0d issues expected 0 0", obs_resp.size(), obs_issue.size());
    end
  endtask

  initial begin
    test_reset();
    test_init();
    test_single_write();
    test_stale_ready();
    test_push_pop_same();
    test_random();
    test_init_backlog();
    test_reset_in_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
